mpt_mem_responder: RTL and testbench

Memory-side responder for the MPT walker's req/gnt/rvalid read port. It backs the walker's table fetches with an internal doubleword table RAM and applies programmable grant and response latencies. It returns in-order responses and flags access faults for out-of-range or misaligned addresses. It sits opposite the walker in block-level and subsystem benches, and it is the reference memory model for MPT lookup verification.

---
 rtl/mpt_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_mpt_mem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mpt_mem_responder.sv
// Memory-side responder for the MPT walker: a doubleword table RAM behind a
// req/gnt/rvalid read port with programmable grant and response latencies.
module mpt_mem_responder #(
  parameter int              XLEN            = 64,
  parameter int              DEPTH           = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR       = '0,
  parameter int              GNT_LAT         = 1,
  parameter int              RVALID_LAT      = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic [XLEN-1:0]          addr_i,
  input  logic                     we_i,
  input  logic [XLEN-1:0]          wdata_i,
  input  logic [XLEN/8-1:0]        be_i,
  output logic                     gnt_o,
  output logic                     rvalid_o,
  output logic [XLEN-1:0]          rdata_o,
  output logic                     err_o,
  input  logic                     bd_we_i,
  input  logic [$clog2(DEPTH)-1:0] bd_idx_i,
  input  logic [XLEN-1:0]          bd_wdata_i
);

  // Handshake: the requester holds req_i and its payload until gnt_o; a transfer
  // happens in the cycle req_i && gnt_o, and every transfer produces exactly one
  // rvalid_o pulse RVALID_LAT cycles later, in grant order (no backpressure).

  localparam int NB = XLEN / 8;
  localparam int AL = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int WW = 4;

  localparam logic [WW-1:0]   GNT_LAT_W = WW'(GNT_LAT);
  localparam logic [OW-1:0]   MAX_OUT_W = OW'(MAX_OUTSTANDING);
  localparam logic [XLEN-1:0] DEPTH_W   = XLEN'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t          state_q;
  logic [WW-1:0]   wcnt_q;
  logic [OW-1:0]   out_q;
  logic [OW-1:0]   out_d;
  logic            credit;
  logic            gnt;

  logic [XLEN-1:0] mem_q [DEPTH];

  logic [XLEN-1:0] off;
  logic [XLEN-1:0] word;
  logic [IW-1:0]   idx;
  logic            acc_err;

  logic [RVALID_LAT-1:0] pv_q;
  logic [RVALID_LAT-1:0] pe_q;
  logic [XLEN-1:0]       pd_q [RVALID_LAT];
  logic [XLEN-1:0]       rd_d;

  assign credit = (out_q < MAX_OUT_W);

  // Grant depends only on registered state, the registered credit and req_i.
  always_comb begin
    gnt = 1'b0;
    if (!rst_i && req_i && credit) begin
      case (state_q)
        S_IDLE:  gnt = (GNT_LAT == 0);
        S_WAIT:  gnt = (wcnt_q == GNT_LAT_W);
        S_STALL: gnt = 1'b1;
        default: gnt = 1'b0;
      endcase
    end
  end

  assign gnt_o = gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_i && (GNT_LAT != 0)) begin
            state_q <= S_WAIT;
            wcnt_q  <= WW'(1);
          end
        end
        S_WAIT: begin
          if (!req_i) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
          end else if (wcnt_q == GNT_LAT_W) begin
            state_q <= credit ? S_IDLE : S_STALL;
            wcnt_q  <= credit ? '0 : wcnt_q;
          end else begin
            wcnt_q <= wcnt_q + WW'(1);
          end
        end
        S_STALL: begin
          if (!req_i || credit) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          wcnt_q  <= '0;
        end
      endcase
    end
  end

  // A grant and a retiring response in the same cycle cancel out.
  always_comb begin
    out_d = out_q;
    if (gnt && !rvalid_o) begin
      out_d = out_q + OW'(1);
    end else if (!gnt && rvalid_o) begin
      out_d = out_q - OW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  // Address decode: below base, misaligned, or beyond the table is a fault.
  always_comb begin
    off     = addr_i - BASE_ADDR;
    word    = off >> AL;
    idx     = word[IW-1:0];
    acc_err = (addr_i < BASE_ADDR) || (off[AL-1:0] != '0) || (word >= DEPTH_W);
  end

  always_comb begin
    rd_d = '0;
    if (gnt && !we_i && !acc_err) begin
      rd_d = mem_q[idx];
    end
  end

  // Front-door bytes are assigned after the backdoor word so they win on a tie.
  always_ff @(posedge clk_i) begin
    if (bd_we_i) begin
      mem_q[bd_idx_i] <= bd_wdata_i;
    end
    if (gnt && we_i && !acc_err) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem_q[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int s = 0; s < RVALID_LAT; s++) begin
        pd_q[s] <= '0;
      end
    end else begin
      for (int s = RVALID_LAT - 1; s > 0; s--) begin
        pv_q[s] <= pv_q[s-1];
        pe_q[s] <= pe_q[s-1];
        pd_q[s] <= pd_q[s-1];
      end
      pv_q[0] <= gnt;
      pe_q[0] <= gnt && acc_err;
      pd_q[0] <= rd_d;
    end
  end

  assign rvalid_o = pv_q[RVALID_LAT-1];
  assign err_o    = pe_q[RVALID_LAT-1];
  assign rdata_o  = pd_q[RVALID_LAT-1];

endmodule

// File: tb/tb_mpt_mem_responder.sv
// Bench for mpt_mem_responder: three parameterisations driven by directed and
// random requests, checked against a transaction-level memory/timing model.
module tb_mpt_mem_responder;

  localparam int NI = 3;

  function automatic int cfg_gl(input int i);
    return (i == 2) ? 0 : 1;
  endfunction
  function automatic int cfg_rl(input int i);
    return (i == 1) ? 4 : 2;
  endfunction
  function automatic int cfg_mo(input int i);
    return (i == 1) ? 1 : 2;
  endfunction
  function automatic logic [63:0] cfg_base(input int i);
    return (i == 1) ? 64'h1000 : 64'h0;
  endfunction

  function automatic bit addr_bad(input longint unsigned a, input longint unsigned base);
    return (a < base) || (a % 8 != 0) || ((a - base) / 8 >= 1024);
  endfunction

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  logic        rst_r   [NI];
  logic        req_r   [NI];
  logic        we_r    [NI];
  logic        bd_we_r [NI];
  logic [63:0] addr_r  [NI];
  logic [63:0] wdata_r [NI];
  logic [63:0] bd_wd_r [NI];
  logic [7:0]  be_r    [NI];
  logic [9:0]  bd_idx_r[NI];
  logic [NI-1:0] gnt_v;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int GL = cfg_gl(g);
    localparam int RL = cfg_rl(g);
    localparam int MO = cfg_mo(g);
    localparam logic [63:0] BASE = cfg_base(g);

    logic        gnt, rvalid, err;
    logic [63:0] rdata;

    mpt_mem_responder #(
      .XLEN(64), .DEPTH(1024), .BASE_ADDR(BASE),
      .GNT_LAT(GL), .RVALID_LAT(RL), .MAX_OUTSTANDING(MO)
    ) u_dut (
      .clk_i(clk), .rst_i(rst_r[g]), .req_i(req_r[g]), .addr_i(addr_r[g]),
      .we_i(we_r[g]), .wdata_i(wdata_r[g]), .be_i(be_r[g]),
      .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
      .bd_we_i(bd_we_r[g]), .bd_idx_i(bd_idx_r[g]), .bd_wdata_i(bd_wd_r[g])
    );

    assign gnt_v[g] = gnt;

    // scoreboard: memory image plus queue of pending responses
    logic [63:0] mem_m [1024];
    logic [63:0] exp_q[$];
    logic        exp_err_q[$];
    int          exp_due_q[$];
    int          start    = -1;
    bit          prev_rst = 1'b0;
    int          obs_out  = 0;

    always @(negedge clk) begin : mon
      bit          cr, eg, er, bad;
      logic [63:0] rd, mask;
      int          w;
      if (rst_r[g]) begin
        check($sformatf("i%0d_rst_gnt", g), gnt, 0);
        exp_q.delete(); exp_err_q.delete(); exp_due_q.delete();
        start    = -1;
        obs_out  = 0;
        prev_rst = 1'b1;
        if (bd_we_r[g]) mem_m[bd_idx_r[g]] = bd_wd_r[g];
      end else begin
        if (prev_rst) begin
          check($sformatf("i%0d_rst_rvalid", g), rvalid, 0);
          check($sformatf("i%0d_rst_rdata", g), rdata, 0);
          check($sformatf("i%0d_rst_err", g), err, 0);
        end
        prev_rst = 1'b0;
        cr = (exp_q.size() < MO);
        if (!req_r[g]) start = -1;
        else if (start < 0) start = cyc;
        eg = req_r[g] && (cyc >= start + GL) && cr;
        check($sformatf("i%0d_gnt", g), gnt, eg);
        er = (exp_due_q.size() > 0) && (exp_due_q[0] == cyc);
        check($sformatf("i%0d_rvalid", g), rvalid, er);
        if (er) begin
          check($sformatf("i%0d_rdata", g), rdata, exp_q[0]);
          check($sformatf("i%0d_err", g), err, exp_err_q[0]);
          void'(exp_q.pop_front()); void'(exp_err_q.pop_front()); void'(exp_due_q.pop_front());
        end
        obs_out = obs_out + int'(gnt) - int'(rvalid);
        if (gnt) check($sformatf("i%0d_outstanding_le_max", g), obs_out <= MO, 1);
        bad = 1'b0;
        w   = 0;
        if (eg) begin
          bad = addr_bad(addr_r[g], BASE);
          w   = bad ? 0 : int'((addr_r[g] - BASE) / 8);
          rd  = (we_r[g] || bad) ? 64'h0 : mem_m[w];
          exp_q.push_back(rd);
          exp_err_q.push_back(bad);
          exp_due_q.push_back(cyc + RL);
          start = -1;
        end
        if (bd_we_r[g]) mem_m[bd_idx_r[g]] = bd_wd_r[g];
        if (eg && we_r[g] && !bad) begin
          mask = '0;
          for (int b = 0; b < 8; b++) if (be_r[g][b]) mask = mask | (64'hFF << (8 * b));
          mem_m[w] = (mem_m[w] & ~mask) | (wdata_r[g] & mask);
        end
      end
    end
  end

  // driver tasks: callers start at posedge+1 and return at posedge+1
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [63:0] a, input logic w,
                      input logic [63:0] d, input logic [7:0] b);
    int n;
    req_r[i] = 1'b1; addr_r[i] = a; we_r[i] = w; wdata_r[i] = d; be_r[i] = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt_v[i] && n < 100);
    if (!gnt_v[i]) check($sformatf("i%0d_gnt_timeout", i), gnt_v[i], 1);
    @(posedge clk);
    #1;
    req_r[i] = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks);
    $fatal(1);
  end

  initial begin
    logic [63:0] a, base;
    int          sel, k, gap;
    for (int i = 0; i < NI; i++) begin
      rst_r[i] = 1'b1; req_r[i] = 1'b0; we_r[i] = 1'b0; bd_we_r[i] = 1'b0;
      addr_r[i] = '0; wdata_r[i] = '0; bd_wd_r[i] = '0; be_r[i] = '0; bd_idx_r[i] = '0;
    end
    idle(3);
    for (int i = 0; i < NI; i++) rst_r[i] = 1'b0;

    // preload words 0..63 of every instance through the backdoor
    for (int w = 0; w < 64; w++) begin
      for (int i = 0; i < NI; i++) begin
        bd_we_r[i]  = 1'b1;
        bd_idx_r[i] = 10'(w);
        bd_wd_r[i]  = (w == 5) ? 64'hDEAD_BEEF_0000_0001 : (w == 2) ? 64'h0 : {$urandom, $urandom};
      end
      idle(1);
    end
    for (int i = 0; i < NI; i++) bd_we_r[i] = 1'b0;
    idle(2);

    // basic read, byte-enabled write, faulting accesses
    send(0, 64'h28, 1'b0, 64'h0, 8'h00);
    idle(3);
    send(0, 64'h10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    send(0, 64'h10, 1'b0, 64'h0, 8'h00);
    idle(3);
    send(0, 64'h2004, 1'b0, 64'h0, 8'h00);
    send(0, 64'h2000, 1'b0, 64'h0, 8'h00);
    send(0, 64'h2000, 1'b1, 64'h1234, 8'hFF);
    send(0, 64'h14, 1'b1, 64'h5555_5555_5555_5555, 8'hFF);
    send(0, 64'h10, 1'b0, 64'h0, 8'h00);
    idle(4);

    // single outstanding credit with long response latency
    send(1, 64'h1000, 1'b0, 64'h0, 8'h00);
    send(1, 64'h1008, 1'b0, 64'h0, 8'h00);
    send(1, 64'h1010, 1'b0, 64'h0, 8'h00);
    idle(6);

    // zero grant latency: grants and retirements overlap
    for (int j = 0; j < 5; j++) send(2, 64'(8 * (j + 3)), 1'b0, 64'h0, 8'h00);
    idle(4);

    // backdoor and front-door write to the same word in the same cycle
    bd_we_r[2] = 1'b1; bd_idx_r[2] = 10'd7; bd_wd_r[2] = 64'h1111_2222_3333_4444;
    send(2, 64'h38, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0);
    bd_we_r[2] = 1'b0;
    send(2, 64'h38, 1'b0, 64'h0, 8'h00);
    idle(4);

    // reset one cycle after a grant drops the response; RAM survives
    send(0, 64'h28, 1'b0, 64'h0, 8'h00);
    rst_r[0] = 1'b1;
    idle(1);
    rst_r[0] = 1'b0;
    idle(4);
    send(0, 64'h28, 1'b0, 64'h0, 8'h00);
    idle(4);

    // randomized traffic
    for (int i = 0; i < NI; i++) begin
      base = cfg_base(i);
      for (int n = 0; n < 120; n++) begin
        sel = $urandom_range(0, 9);
        k   = $urandom_range(0, 63);
        if (sel <= 6)      a = base + 64'(8 * k);
        else if (sel == 7) a = base + 64'(8 * k + $urandom_range(1, 7));
        else if (sel == 8) a = base + 64'(8 * (1024 + $urandom_range(0, 100)));
        else               a = (base > 0) ? base - 64'(8 * $urandom_range(1, 4)) : base + 64'(8 * k);
        send(i, a, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom));
        gap = $urandom_range(0, 3);
        if (gap == 3) begin
          bd_we_r[i] = 1'b1; bd_idx_r[i] = 10'($urandom_range(0, 63)); bd_wd_r[i] = {$urandom, $urandom};
          idle(1);
          bd_we_r[i] = 1'b0;
        end else begin
          idle(gap);
        end
      end
      idle(8);
    end

    idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
